// File: rtl/regfile.sv
// regfile: 2**ADDR_W x DATA_W register file with two combinational read ports; entry 0 reads as zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    // Entry 0 is never written, so it holds its reset value of zero forever.
    always_comb begin
        mem_d = mem_q;
        if (we && waddr != '0) mem_d[waddr] = wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mem_q <= '{default: '0};
        else     mem_q <= mem_d;
    end

`ifdef REGFILE_BYPASS_EN
    assign rdata1 = (rst || !re1 || raddr1 == '0) ? '0 :
                    (we && raddr1 == waddr) ? wdata : mem_q[raddr1];
    assign rdata2 = (rst || !re2 || raddr2 == '0) ? '0 :
                    (we && raddr2 == waddr) ? wdata : mem_q[raddr2];
`else
    assign rdata1 = (rst || !re1 || raddr1 == '0) ? '0 : mem_q[raddr1];
    assign rdata2 = (rst || !re2 || raddr2 == '0) ? '0 : mem_q[raddr2];
`endif
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed self-checking bench for regfile (default or REGFILE_BYPASS_EN build).
module tb_regfile;
    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    int tests = 0;
    int fails = 0;

    regfile dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; waddr = a; wdata = d;
        @(posedge clk);
        #1 we = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
        re1 = 1'b1; raddr1 = a1; re2 = 1'b1; raddr2 = a2;
        #1;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        re1 = 1'b1; raddr1 = 5'd1; re2 = 1'b1; raddr2 = 5'd2;
        #12;
        chk("rst_rd1", rdata1, 32'h0);
        chk("rst_rd2", rdata2, 32'h0);
        @(negedge clk); rst = 1'b0;
        rd(5'd1, 5'd31);
        chk("post_rst_r1", rdata1, 32'h0);
        chk("post_rst_r31", rdata2, 32'h0);

        wr(5'd5, 32'h1234);
        rd(5'd5, 5'd5);
        chk("pre_r5", rdata1, 32'h1234);
        @(negedge clk); #1 rst = 1'b1;
        #1;
        chk("async_rst_rd1", rdata1, 32'h0);
        chk("async_rst_rd2", rdata2, 32'h0);
        #1 rst = 1'b0;
        #1;
        chk("r5_cleared", rdata1, 32'h0);

        @(negedge clk);
        we = 1'b1; waddr = 5'd8; wdata = 32'h99; rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; we = 1'b0;
        rd(5'd8, 5'd8);
        chk("mid_write_rst", rdata1, 32'h0);
        wr(5'd8, 32'h99);
        rd(5'd8, 5'd8);
        chk("resume_write", rdata2, 32'h99);

        wr(5'd3, 32'hDEADBEEF);
        rd(5'd3, 5'd3);
        chk("basic_rd", rdata1, 32'hDEADBEEF);
        re1 = 1'b0; #1;
        chk("re1_off", rdata1, 32'h0);
        re2 = 1'b0; #1;
        chk("re2_off", rdata2, 32'h0);

        wr(5'd0, 32'hFFFFFFFF);
        rd(5'd0, 5'd0);
        chk("zero_rd1", rdata1, 32'h0);
        chk("zero_rd2", rdata2, 32'h0);

        wr(5'd7, 32'h11);
        wr(5'd9, 32'h22);
        rd(5'd7, 5'd9);
        chk("dual_rd1", rdata1, 32'h11);
        chk("dual_rd2", rdata2, 32'h22);
        rd(5'd9, 5'd9);
        chk("same_addr_rd1", rdata1, 32'h22);
        chk("same_addr_rd2", rdata2, 32'h22);
        rd(5'd3, 5'd8);
        chk("r3_kept", rdata1, 32'hDEADBEEF);
        chk("r8_kept", rdata2, 32'h99);

        wr(5'd4, 32'hA);
        @(negedge clk);
        we = 1'b1; waddr = 5'd4; wdata = 32'hB;
        rd(5'd4, 5'd7);
`ifdef REGFILE_BYPASS_EN
        chk("same_cycle_rd", rdata1, 32'hB);
`else
        chk("same_cycle_rd", rdata1, 32'hA);
`endif
        chk("same_cycle_other", rdata2, 32'h11);
        @(posedge clk);
        #1 we = 1'b0;
        #1;
        chk("next_cycle_rd", rdata1, 32'hB);

        wr(5'd6, 32'h77);
        @(negedge clk);
        we = 1'b0; waddr = 5'd6; wdata = 32'h55;
        @(posedge clk);
        rd(5'd6, 5'd6);
        chk("we_off_keep", rdata1, 32'h77);

        wr(5'd31, 32'hCAFEF00D);
        rd(5'd31, 5'd1);
        chk("top_entry", rdata1, 32'hCAFEF00D);
        chk("r1_untouched", rdata2, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
